// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcode/ext fields,
// condition codes, FSM states, instruction classes and datapath select values.
package cpu_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ANDI  = 4'h1;
    localparam logic [3:0] OP_ORI   = 4'h2;
    localparam logic [3:0] OP_XORI  = 4'h3;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_BCOND = 4'hC;
    localparam logic [3:0] OP_LUI   = 4'hF;

    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STOR  = 4'h4;
    localparam logic [3:0] EXT_JAL   = 4'h8;
    localparam logic [3:0] EXT_JCOND = 4'hC;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_HI = 4'h4;
    localparam logic [3:0] CC_LS = 4'h5;
    localparam logic [3:0] CC_GT = 4'h6;
    localparam logic [3:0] CC_LE = 4'h7;
    localparam logic [3:0] CC_FS = 4'h8;
    localparam logic [3:0] CC_FC = 4'h9;
    localparam logic [3:0] CC_LO = 4'hA;
    localparam logic [3:0] CC_HS = 4'hB;
    localparam logic [3:0] CC_LT = 4'hC;
    localparam logic [3:0] CC_GE = 4'hD;
    localparam logic [3:0] CC_UC = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC1 = 2'd2;

    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_DISP = 2'd1;
    localparam logic [1:0] PC_REG  = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_LOADIR = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_ALU   = 4'd0,
        C_IMM   = 4'd1,
        C_LUI   = 4'd2,
        C_LOAD  = 4'd3,
        C_STOR  = 4'd4,
        C_JAL   = 4'd5,
        C_JCOND = 4'd6,
        C_BCOND = 4'd7,
        C_HALT  = 4'd8,
        C_NOP   = 4'd9
    } cls_e;

    // Undefined ext values under op 0100 retire as a plain PC increment.
    function automatic cls_e decode_cls(input logic [15:0] ir);
        cls_e cls;
        cls = C_IMM;
        if (ir == 16'h0000) begin
            cls = C_HALT;
        end else begin
            case (ir[15:12])
                OP_RTYPE: cls = C_ALU;
                OP_BCOND: cls = C_BCOND;
                OP_LUI:   cls = C_LUI;
                OP_MEM: begin
                    case (ir[7:4])
                        EXT_LOAD:  cls = C_LOAD;
                        EXT_STOR:  cls = C_STOR;
                        EXT_JAL:   cls = C_JAL;
                        EXT_JCOND: cls = C_JCOND;
                        default:   cls = C_NOP;
                    endcase
                end
                default: cls = C_IMM;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator: maps a 4-bit condition code and the
// PSR flags {C, F, L, Z, N} to a taken decision.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [4:0] conds_i,
    output logic       taken_o
);

    logic flag_c, flag_f, flag_l, flag_z, flag_n;

    assign flag_c = conds_i[4];
    assign flag_f = conds_i[3];
    assign flag_l = conds_i[2];
    assign flag_z = conds_i[1];
    assign flag_n = conds_i[0];

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            CC_EQ: taken_o = flag_z;
            CC_NE: taken_o = !flag_z;
            CC_CS: taken_o = flag_c;
            CC_CC: taken_o = !flag_c;
            CC_HI: taken_o = flag_l;
            CC_LS: taken_o = !flag_l;
            CC_GT: taken_o = flag_n;
            CC_LE: taken_o = !flag_n;
            CC_FS: taken_o = flag_f;
            CC_FC: taken_o = !flag_f;
            CC_LO: taken_o = !flag_l && !flag_z;
            CC_HS: taken_o = flag_l || flag_z;
            CC_LT: taken_o = !flag_n && !flag_z;
            CC_GE: taken_o = flag_n || flag_z;
            CC_UC: taken_o = 1'b1;
            CC_NV: taken_o = 1'b0;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle fetch/decode/control unit: holds IR, sequences
// FETCH -> LOADIR -> EXEC [-> MEM -> WB] and drives the datapath controls.
module ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int SIZE   = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SIZE-1:0]   memdata,
    input  logic [4:0]        conds,
    output logic [REG_AW-1:0] src_addr,
    output logic [REG_AW-1:0] dst_addr,
    output logic [SIZE-1:0]   imm,
    output logic [7:0]        alu_op,
    output logic              alu_sel_a,
    output logic              alu_sel_b,
    output logic              reg_we,
    output logic              psr_we,
    output logic [1:0]        wb_sel,
    output logic              mem_we,
    output logic              adr_sel,
    output logic              pc_en,
    output logic [1:0]        pc_src,
    output logic              halted
);

    state_e          state_q;
    logic [SIZE-1:0] ir_q;
    cls_e            cls;
    logic [3:0]      op;
    logic [3:0]      ext;
    logic            taken;

    assign op  = ir_q[15:12];
    assign ext = ir_q[7:4];
    assign cls = decode_cls(ir_q[15:0]);

    cond_eval u_cond_eval (
        .cond_i  (ir_q[11:8]),
        .conds_i (conds),
        .taken_o (taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_LOADIR;
                S_LOADIR: begin
                    ir_q    <= memdata;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (cls == C_HALT)      state_q <= S_HALT;
                    else if (cls == C_LOAD) state_q <= S_MEM;
                    else                    state_q <= S_FETCH;
                end
                S_MEM:    state_q <= S_WB;
                S_WB:     state_q <= S_FETCH;
                S_HALT:   state_q <= S_HALT;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Instruction fields follow IR directly so they stay stable EXEC..WB.
    assign src_addr = ir_q[REG_AW-1:0];
    assign dst_addr = ir_q[8 +: REG_AW];
    assign alu_op   = (cls == C_ALU) ? {op, ext} : {op, 4'h0};

    always_comb begin
        imm = {{(SIZE-8){ir_q[7]}}, ir_q[7:0]};
        if (op == OP_LUI) begin
            imm = {ir_q[7:0], {(SIZE-8){1'b0}}};
        end else if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) begin
            imm = {{(SIZE-8){1'b0}}, ir_q[7:0]};
        end
    end

    // Controls are gated by reset so a reset landing in MEM/WB never strobes.
    always_comb begin
        alu_sel_a = 1'b0;
        alu_sel_b = 1'b0;
        reg_we    = 1'b0;
        psr_we    = 1'b0;
        wb_sel    = WB_ALU;
        mem_we    = 1'b0;
        adr_sel   = 1'b0;
        pc_en     = 1'b0;
        pc_src    = PC_INC;
        halted    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_EXEC: begin
                    case (cls)
                        C_ALU: begin
                            reg_we = 1'b1;
                            psr_we = 1'b1;
                            pc_en  = 1'b1;
                        end
                        C_IMM: begin
                            alu_sel_b = 1'b1;
                            reg_we    = 1'b1;
                            psr_we    = 1'b1;
                            pc_en     = 1'b1;
                        end
                        C_LUI: begin
                            alu_sel_b = 1'b1;
                            reg_we    = 1'b1;
                            pc_en     = 1'b1;
                        end
                        C_BCOND: begin
                            pc_en  = 1'b1;
                            pc_src = taken ? PC_DISP : PC_INC;
                        end
                        C_JCOND: begin
                            pc_en  = 1'b1;
                            pc_src = taken ? PC_REG : PC_INC;
                        end
                        C_JAL: begin
                            reg_we = 1'b1;
                            wb_sel = WB_PC1;
                            pc_en  = 1'b1;
                            pc_src = PC_REG;
                        end
                        C_STOR: begin
                            adr_sel = 1'b1;
                            mem_we  = 1'b1;
                            pc_en   = 1'b1;
                        end
                        C_LOAD:  adr_sel = 1'b1;
                        C_NOP:   pc_en   = 1'b1;
                        default: ;
                    endcase
                end
                S_MEM: adr_sel = 1'b1;
                S_WB: begin
                    reg_we = 1'b1;
                    wb_sel = WB_MEM;
                    pc_en  = 1'b1;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: the driver pushes per-cycle expected controls,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ctrl_fsm;

    localparam int SIZE   = 16;
    localparam int REG_AW = 4;
    localparam int CW     = 12;
    localparam int FW     = 32;
    localparam int W      = 1 + FW + CW;

    logic              clk = 1'b1;
    logic              reset;
    logic [SIZE-1:0]   memdata;
    logic [4:0]        conds;
    logic [REG_AW-1:0] src_addr;
    logic [REG_AW-1:0] dst_addr;
    logic [SIZE-1:0]   imm;
    logic [7:0]        alu_op;
    logic              alu_sel_a;
    logic              alu_sel_b;
    logic              reg_we;
    logic              psr_we;
    logic [1:0]        wb_sel;
    logic              mem_we;
    logic              adr_sel;
    logic              pc_en;
    logic [1:0]        pc_src;
    logic              halted;

    always #5 clk = ~clk;

    ctrl_fsm #(.SIZE(SIZE), .REG_AW(REG_AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .memdata   (memdata),
        .conds     (conds),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .imm       (imm),
        .alu_op    (alu_op),
        .alu_sel_a (alu_sel_a),
        .alu_sel_b (alu_sel_b),
        .reg_we    (reg_we),
        .psr_we    (psr_we),
        .wb_sel    (wb_sel),
        .mem_we    (mem_we),
        .adr_sel   (adr_sel),
        .pc_en     (pc_en),
        .pc_src    (pc_src),
        .halted    (halted)
    );

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [CW-1:0] IDLE = '0;

    function automatic logic [CW-1:0] ctl(input logic sa, input logic sb, input logic rw,
                                          input logic pw, input logic [1:0] wb, input logic mw,
                                          input logic ad, input logic pe, input logic [1:0] ps,
                                          input logic h);
        return {sa, sb, rw, pw, wb, mw, ad, pe, ps, h};
    endfunction

    // Monitor: one expected entry per cycle, compared away from the rising edge.
    always @(negedge clk) begin
        logic [W-1:0]  e;
        logic [CW-1:0] act_c;
        logic [FW-1:0] act_f;
        cyc = cyc + 1;
        if (exp_q.size() > 0) begin
            e     = exp_q.pop_front();
            act_c = {alu_sel_a, alu_sel_b, reg_we, psr_we, wb_sel, mem_we,
                     adr_sel, pc_en, pc_src, halted};
            act_f = {src_addr, dst_addr, imm, alu_op};
            checks = checks + 1;
            if (act_c !== e[CW-1:0]) begin
                errors = errors + 1;
                $display("FAIL ctrl cyc=%0d got=%h want=%h", cyc, act_c, e[CW-1:0]);
            end
            if (e[W-1]) begin
                checks = checks + 1;
                if (act_f !== e[CW +: FW]) begin
                    errors = errors + 1;
                    $display("FAIL fields cyc=%0d got=%h want=%h", cyc, act_f, e[CW +: FW]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_exp(input logic chk, input logic [FW-1:0] f, input logic [CW-1:0] c);
        exp_q.push_back({chk, f, c});
        tick();
    endtask

    task automatic run_instr(input logic [15:0] ir, input logic [4:0] cnd,
                             input logic [3:0] src, input logic [3:0] dst,
                             input logic [15:0] im, input logic [7:0] alu,
                             input logic [CW-1:0] exec_c, input logic is_load);
        logic [FW-1:0] f;
        f = {src, dst, im, alu};
        memdata = 16'hA5A5;
        conds   = ~cnd;
        cyc_exp(1'b0, '0, IDLE);
        memdata = ir;
        cyc_exp(1'b0, '0, IDLE);
        memdata = 16'h5A5A;
        conds   = cnd;
        cyc_exp(1'b1, f, exec_c);
        conds   = ~cnd;
        if (is_load) begin
            cyc_exp(1'b1, f, ctl(0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0));
            cyc_exp(1'b1, f, ctl(0, 0, 1, 0, 2'd1, 0, 0, 1, 2'd0, 0));
        end
    endtask

    initial begin
        reset   = 1'b1;
        memdata = '0;
        conds   = '0;
        cyc_exp(1'b0, '0, IDLE);
        cyc_exp(1'b0, '0, IDLE);
        reset = 1'b0;

        // ADD, ADDI, LUI, ORI (zero-extended)
        run_instr(16'h0152, 5'b00000, 4'h2, 4'h1, 16'h0052, 8'h05,
                  ctl(0, 0, 1, 1, 2'd0, 0, 0, 1, 2'd0, 0), 1'b0);
        run_instr(16'h53F6, 5'b00000, 4'h6, 4'h3, 16'hFFF6, 8'h50,
                  ctl(0, 1, 1, 1, 2'd0, 0, 0, 1, 2'd0, 0), 1'b0);
        run_instr(16'hF3AB, 5'b00000, 4'hB, 4'h3, 16'hAB00, 8'hF0,
                  ctl(0, 1, 1, 0, 2'd0, 0, 0, 1, 2'd0, 0), 1'b0);
        run_instr(16'h2185, 5'b00000, 4'h5, 4'h1, 16'h0085, 8'h20,
                  ctl(0, 1, 1, 1, 2'd0, 0, 0, 1, 2'd0, 0), 1'b0);

        // Bcond EQ taken / not taken, UC always taken
        run_instr(16'hC0FE, 5'b00010, 4'hE, 4'h0, 16'hFFFE, 8'hC0,
                  ctl(0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd1, 0), 1'b0);
        run_instr(16'hC0FE, 5'b00000, 4'hE, 4'h0, 16'hFFFE, 8'hC0,
                  ctl(0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 0), 1'b0);
        run_instr(16'hCE05, 5'b00000, 4'h5, 4'hE, 16'h0005, 8'hC0,
                  ctl(0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd1, 0), 1'b0);

        // Jcond LO taken (flags clear), Jcond HS not taken, JAL
        run_instr(16'h4AC3, 5'b00000, 4'h3, 4'hA, 16'hFFC3, 8'h40,
                  ctl(0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd2, 0), 1'b0);
        run_instr(16'h4BC3, 5'b00000, 4'h3, 4'hB, 16'hFFC3, 8'h40,
                  ctl(0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 0), 1'b0);
        run_instr(16'h4782, 5'b00000, 4'h2, 4'h7, 16'hFF82, 8'h40,
                  ctl(0, 0, 1, 0, 2'd2, 0, 0, 1, 2'd2, 0), 1'b0);

        // STOR, LOAD
        run_instr(16'h4546, 5'b00000, 4'h6, 4'h5, 16'h0046, 8'h40,
                  ctl(0, 0, 0, 0, 2'd0, 1, 1, 1, 2'd0, 0), 1'b0);
        run_instr(16'h4302, 5'b00000, 4'h2, 4'h3, 16'h0002, 8'h40,
                  ctl(0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0), 1'b1);

        // HALT then 20 idle cycles
        run_instr(16'h0000, 5'b00000, 4'h0, 4'h0, 16'h0000, 8'h00, IDLE, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc_exp(1'b1, '0, ctl(0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 1));
        end

        // Leave HALT by reset, then reset again while LOAD sits in MEM
        reset = 1'b1;
        cyc_exp(1'b0, '0, IDLE);
        reset   = 1'b0;
        memdata = 16'hA5A5;
        cyc_exp(1'b0, '0, IDLE);
        memdata = 16'h4302;
        cyc_exp(1'b0, '0, IDLE);
        memdata = 16'h5A5A;
        cyc_exp(1'b1, {4'h2, 4'h3, 16'h0002, 8'h40}, ctl(0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0));
        reset = 1'b1;
        cyc_exp(1'b0, '0, IDLE);
        reset = 1'b0;

        // Normal operation resumes from FETCH
        run_instr(16'h0152, 5'b00000, 4'h2, 4'h1, 16'h0052, 8'h05,
                  ctl(0, 0, 1, 1, 2'd0, 0, 0, 1, 2'd0, 0), 1'b0);

        tick();
        tick();
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors = errors + 1;
        $display("FAIL timeout got=running want=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
